skid_buffer: RTL and testbench

//   Two-entry valid/ready pipeline register (skid buffer) between pipeline stages.

---
 rtl/skid_buffer.sv | 130 +++++++++++++
 tb/tb_skid_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - two-entry valid/ready skid buffer with registered in_ready
//
// Cuts the ready timing path between two pipeline stages. The main register
// drives out_data; the skid register catches the one word that arrives while
// the consumer stalls. in_ready, out_valid and count come straight from flops,
// so out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   flush      in   1      synchronous discard of all held entries
//   in_valid   in   1      producer presents in_data
//   in_ready   out  1      buffer can accept (registered)
//   in_data    in   Width  producer word
//   out_valid  out  1      out_data holds a valid word
//   out_ready  in   1      consumer accepts out_data this cycle
//   out_data   out  Width  head word (registered)
//   count      out  2      entries held: 0, 1 or 2
module skid_buffer #(
    parameter int               Width      = 32,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [Width-1:0] main_q, main_d;
    logic [Width-1:0] skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [1:0]       count_q, count_d;

    logic in_fire;
    logic out_fire;

    // Both handshakes are qualified by registered flags only.
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    // Consumer stalled: park the new word, head stays put.
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    // main keeps the last word; out_valid drops.
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush wins over everything; an accepted input word is dropped and
        // the data registers keep whatever they held.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end

        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
        case (state_d)
            ONE:     count_d = 2'd1;
            FULL:    count_d = 2'd2;
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            main_q      <= ResetValue;
            skid_q      <= ResetValue;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            count_q     <= count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign count     = count_q;

endmodule

// File: tb/tb_skid_buffer.sv
// tb/tb_skid_buffer.sv - directed and scoreboarded bench for skid_buffer
module tb_skid_buffer;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  count;

    int vectors;
    int miscompares;

    skid_buffer #(
        .Width      (32),
        .ResetValue (32'h0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        vectors++;
        if (count !== 2'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
        vectors++;
        if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    endtask

    task automatic test_first_word();
        in_valid  = 1'b1;
        in_data   = 32'hA5;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL first_out_valid got=%0b exp=1", out_valid); end
        vectors++;
        if (out_data !== 32'hA5) begin miscompares++; $display("FAIL first_out_data got=%h exp=a5", out_data); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL first_in_ready got=%0b exp=1", in_ready); end
        vectors++;
        if (count !== 2'd1) begin miscompares++; $display("FAIL first_count got=%0d exp=1", count); end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL first_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_stream();
        for (int i = 0; i <= 16; i++) begin
            in_valid  = (i < 16);
            in_data   = i;
            out_ready = 1'b1;
            if (i >= 1) begin
                vectors++;
                if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d] got=%0b exp=1", i - 1, out_valid); end
                vectors++;
                if (out_data !== 32'(i - 1)) begin miscompares++; $display("FAIL stream_data[%0d] got=%h exp=%h", i - 1, out_data, i - 1); end
            end
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_end got=%0b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data = 32'h22;
        step();
        vectors++;
        if (count !== 2'd2) begin miscompares++; $display("FAIL bp_count got=%0d exp=2", count); end
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
        vectors++;
        if (out_data !== 32'h11) begin miscompares++; $display("FAIL bp_hold got=%h exp=11", out_data); end
        in_data = 32'h33;
        step();
        vectors++;
        if (count !== 2'd2) begin miscompares++; $display("FAIL bp_not_taken_count got=%0d exp=2", count); end
        vectors++;
        if (out_data !== 32'h11) begin miscompares++; $display("FAIL bp_hold2 got=%h exp=11", out_data); end
        out_ready = 1'b1;
        vectors++;
        if (out_data !== 32'h11) begin miscompares++; $display("FAIL bp_drain0 got=%h exp=11", out_data); end
        step();
        vectors++;
        if (out_data !== 32'h22) begin miscompares++; $display("FAIL bp_drain1 got=%h exp=22", out_data); end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h33) begin miscompares++; $display("FAIL bp_drain2 got=%0b/%h exp=1/33", out_valid, out_data); end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data = 32'h22;
        step();
        flush   = 1'b1;
        in_data = 32'h44;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (count !== 2'd0) begin miscompares++; $display("FAIL flush_count got=%0d exp=0", count); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid got=%0b exp=0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        vectors++;
        if (out_data !== 32'h11) begin miscompares++; $display("FAIL flush_data_kept got=%h exp=11", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0 || out_data === 32'h44) begin miscompares++; $display("FAIL flush_no_44 got=%0b/%h exp=0/not44", out_valid, out_data); end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data = 32'h22;
        step();
        in_valid = 1'b0;
        vectors++;
        if (count !== 2'd2) begin miscompares++; $display("FAIL arst_pre_count got=%0d exp=2", count); end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_out_valid got=%0b exp=0", out_valid); end
        vectors++;
        if (count !== 2'd0) begin miscompares++; $display("FAIL arst_count got=%0d exp=0", count); end
        vectors++;
        if (out_data !== 32'h0) begin miscompares++; $display("FAIL arst_out_data got=%h exp=0", out_data); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_in_ready got=%0b exp=1", in_ready); end
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_random();
        logic [31:0] sb[$];
        logic        ifire;
        logic        ofire;
        logic [31:0] head;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = $urandom_range(0, 1);
            out_ready = $urandom_range(0, 1);
            in_data   = $urandom();
            vectors++;
            if (in_ready !== (sb.size() != 2)) begin miscompares++; $display("FAIL rnd_in_ready c=%0d got=%0b exp=%0b", c, in_ready, sb.size() != 2); end
            vectors++;
            if (out_valid !== (sb.size() != 0)) begin miscompares++; $display("FAIL rnd_out_valid c=%0d got=%0b exp=%0b", c, out_valid, sb.size() != 0); end
            vectors++;
            if (count !== 2'(sb.size())) begin miscompares++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, sb.size()); end
            if (c % 16 == 0) begin
                out_ready = ~out_ready;
                #1;
                vectors++;
                if (in_ready !== (sb.size() != 2)) begin miscompares++; $display("FAIL rnd_ready_path c=%0d got=%0b exp=%0b", c, in_ready, sb.size() != 2); end
                out_ready = ~out_ready;
                #1;
            end
            ifire = in_valid && (sb.size() != 2);
            ofire = out_ready && (sb.size() != 0);
            if (ofire) begin
                head = sb.pop_front();
                vectors++;
                if (out_data !== head) begin miscompares++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, out_data, head); end
            end
            if (ifire) sb.push_back(in_data);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_first_word();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
